// File: rtl/xbar_ctrl_reg.sv
// xbar_ctrl_reg: registered crossbar connection map for the router switch stage.
// Turns per-input one-hot allocation rows into per-input output selects and
// per-output input selects. Held connections (multi-flit packets) are kept,
// contention is resolved by lowest input index, and drops are reported.
module xbar_ctrl_reg #(
    parameter int NUM_PORT = 6,
    parameter int CNT_W    = 8,
    parameter int SEL_W    = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [NUM_PORT*NUM_PORT-1:0] alloc_vec,
    input  logic [NUM_PORT-1:0]          hold_vec,
    output logic [NUM_PORT*SEL_W-1:0]    out_sel_vec,
    output logic [NUM_PORT-1:0]          out_vld,
    output logic [NUM_PORT*SEL_W-1:0]    in_sel_vec,
    output logic [NUM_PORT-1:0]          in_vld,
    output logic                         conflict,
    output logic                         multi_hot,
    output logic [CNT_W-1:0]             conflict_cnt
);

    // Index of the highest set bit of an allocation row (0 for an empty row).
    function automatic logic [SEL_W-1:0] hi_bit(input logic [NUM_PORT-1:0] row);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int j = 0; j < NUM_PORT; j++) begin
            if (row[j]) begin
                idx = SEL_W'(j);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when more than one bit of the row is set.
    function automatic logic is_multi(input logic [NUM_PORT-1:0] row);
        return (row & (row - {{(NUM_PORT-1){1'b0}}, 1'b1})) != {NUM_PORT{1'b0}};
    endfunction

    logic [NUM_PORT*SEL_W-1:0] out_sel_r;
    logic [NUM_PORT-1:0]       out_vld_r;
    logic [NUM_PORT*SEL_W-1:0] in_sel_r;
    logic [NUM_PORT-1:0]       in_vld_r;
    logic                      conflict_r;
    logic                      multi_hot_r;
    logic [CNT_W-1:0]          conflict_cnt_r;

    logic [NUM_PORT*SEL_W-1:0] nxt_out_sel_s;
    logic [NUM_PORT-1:0]       nxt_out_vld_s;
    logic [NUM_PORT*SEL_W-1:0] nxt_in_sel_s;
    logic [NUM_PORT-1:0]       nxt_in_vld_s;
    logic [NUM_PORT-1:0]       held_s;
    logic [NUM_PORT-1:0]       taken_s;
    logic [NUM_PORT-1:0]       row_s;
    logic [SEL_W-1:0]          req_s;
    logic                      conflict_s;
    logic                      multi_hot_s;

    // Next connection map: keep held links, decode rows, arbitrate by index, rebuild reverse map.
    always_comb begin
        nxt_out_sel_s = {(NUM_PORT*SEL_W){1'b0}};
        nxt_out_vld_s = {NUM_PORT{1'b0}};
        nxt_in_sel_s  = {(NUM_PORT*SEL_W){1'b0}};
        nxt_in_vld_s  = {NUM_PORT{1'b0}};
        held_s        = out_vld_r & hold_vec;
        taken_s       = {NUM_PORT{1'b0}};
        row_s         = {NUM_PORT{1'b0}};
        req_s         = {SEL_W{1'b0}};
        conflict_s    = 1'b0;
        multi_hot_s   = 1'b0;

        // Held inputs keep their output and reserve it before anyone arbitrates.
        for (int i = 0; i < NUM_PORT; i++) begin
            if (held_s[i]) begin
                nxt_out_sel_s[i*SEL_W +: SEL_W] = out_sel_r[i*SEL_W +: SEL_W];
                nxt_out_vld_s[i]                = 1'b1;
                for (int j = 0; j < NUM_PORT; j++) begin
                    if (out_sel_r[i*SEL_W +: SEL_W] == SEL_W'(j)) begin
                        taken_s[j] = 1'b1;
                    end else begin
                        taken_s[j] = taken_s[j];
                    end
                end
            end else begin
                nxt_out_vld_s[i] = 1'b0;
            end
        end

        // Ascending index order means the first claimant of a free output is the lowest index.
        for (int i = 0; i < NUM_PORT; i++) begin
            row_s = alloc_vec[i*NUM_PORT +: NUM_PORT];
            if (alloc_valid && !held_s[i] && (row_s != {NUM_PORT{1'b0}})) begin
                req_s = hi_bit(row_s);
                multi_hot_s = multi_hot_s | is_multi(row_s);
                for (int j = 0; j < NUM_PORT; j++) begin
                    if (req_s == SEL_W'(j)) begin
                        if (taken_s[j]) begin
                            conflict_s = 1'b1;
                        end else begin
                            taken_s[j]                      = 1'b1;
                            nxt_out_sel_s[i*SEL_W +: SEL_W] = req_s;
                            nxt_out_vld_s[i]                = 1'b1;
                        end
                    end else begin
                        taken_s[j] = taken_s[j];
                    end
                end
            end else begin
                req_s = {SEL_W{1'b0}};
            end
        end

        // Reverse map is derived from the forward map so the two can never disagree.
        for (int i = 0; i < NUM_PORT; i++) begin
            for (int j = 0; j < NUM_PORT; j++) begin
                if (nxt_out_vld_s[i] && (nxt_out_sel_s[i*SEL_W +: SEL_W] == SEL_W'(j))) begin
                    nxt_in_sel_s[j*SEL_W +: SEL_W] = SEL_W'(i);
                    nxt_in_vld_s[j]                = 1'b1;
                end else begin
                    nxt_in_vld_s[j] = nxt_in_vld_s[j];
                end
            end
        end
    end

    // Connection map and report flags register; async clear drops any held packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sel_r   <= {(NUM_PORT*SEL_W){1'b0}};
            out_vld_r   <= {NUM_PORT{1'b0}};
            in_sel_r    <= {(NUM_PORT*SEL_W){1'b0}};
            in_vld_r    <= {NUM_PORT{1'b0}};
            conflict_r  <= 1'b0;
            multi_hot_r <= 1'b0;
        end else begin
            out_sel_r   <= nxt_out_sel_s;
            out_vld_r   <= nxt_out_vld_s;
            in_sel_r    <= nxt_in_sel_s;
            in_vld_r    <= nxt_in_vld_s;
            conflict_r  <= conflict_s;
            multi_hot_r <= multi_hot_s;
        end
    end

    // Saturating count of cycles that dropped at least one request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else if (conflict_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
            conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign out_sel_vec  = out_sel_r;
    assign out_vld      = out_vld_r;
    assign in_sel_vec   = in_sel_r;
    assign in_vld       = in_vld_r;
    assign conflict     = conflict_r;
    assign multi_hot    = multi_hot_r;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_xbar_ctrl_reg.sv
// tb_xbar_ctrl_reg: directed scenarios plus random traffic, checked every cycle
// against a per-output arbitration model of the connection map.
module tb_xbar_ctrl_reg;

    localparam int NP    = 6;
    localparam int SW    = 3;
    localparam int CW    = 8;

    logic              clk;
    logic              rst_n;
    logic              alloc_valid;
    logic [NP*NP-1:0]  alloc_vec;
    logic [NP-1:0]     hold_vec;
    logic [NP*SW-1:0]  out_sel_vec;
    logic [NP-1:0]     out_vld;
    logic [NP*SW-1:0]  in_sel_vec;
    logic [NP-1:0]     in_vld;
    logic              conflict;
    logic              multi_hot;
    logic [CW-1:0]     conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: forward map only; the reverse map is derived when checking
    int m_sel[NP];
    bit m_vld[NP];
    bit m_conf;
    bit m_multi;
    int m_cnt;
    // staged next state
    int n_sel[NP];
    bit n_vld[NP];
    bit n_conf;
    bit n_multi;

    xbar_ctrl_reg #(.NUM_PORT(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_vec(alloc_vec),
        .hold_vec(hold_vec), .out_sel_vec(out_sel_vec), .out_vld(out_vld),
        .in_sel_vec(in_sel_vec), .in_vld(in_vld), .conflict(conflict),
        .multi_hot(multi_hot), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input logic [NP-1:0] v);
        alloc_vec[i*NP +: NP] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_sel[i] = 0;
            m_vld[i] = 1'b0;
        end
        m_conf  = 1'b0;
        m_multi = 1'b0;
        m_cnt   = 0;
    endtask

    // Compute the next map from the current inputs: per output, a held link owns it,
    // otherwise the smallest requesting input index gets it; everyone else is dropped.
    task automatic model_next();
        bit resv[NP];
        int req[NP];
        int r;
        n_conf  = 1'b0;
        n_multi = 1'b0;
        for (int i = 0; i < NP; i++) resv[i] = 1'b0;
        for (int i = 0; i < NP; i++) begin
            bit held;
            held     = m_vld[i] && hold_vec[i];
            n_vld[i] = held;
            n_sel[i] = held ? m_sel[i] : 0;
            if (held) resv[m_sel[i]] = 1'b1;
            req[i] = -1;
            r = int'(alloc_vec[i*NP +: NP]);
            if (!held && alloc_valid && r != 0) begin
                req[i] = $clog2(r + 1) - 1;
                if ($countones(r) > 1) n_multi = 1'b1;
            end
        end
        for (int j = 0; j < NP; j++) begin
            int winner;
            winner = -1;
            for (int i = 0; i < NP; i++) begin
                if (req[i] == j) begin
                    if (resv[j] || winner >= 0) n_conf = 1'b1;
                    else winner = i;
                end
            end
            if (winner >= 0) begin
                n_vld[winner] = 1'b1;
                n_sel[winner] = j;
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < NP; i++) begin
            m_sel[i] = n_sel[i];
            m_vld[i] = n_vld[i];
        end
        m_conf  = n_conf;
        m_multi = n_multi;
        if (n_conf && m_cnt < 255) m_cnt++;
    endtask

    // One clocked update: predict from inputs, take the edge, then adopt the prediction.
    task automatic cyc();
        model_next();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic [NP*SW-1:0] e_out_sel;
        logic [NP*SW-1:0] e_in_sel;
        logic [NP-1:0]    e_out_vld;
        logic [NP-1:0]    e_in_vld;
        e_out_sel = '0;
        e_in_sel  = '0;
        e_out_vld = '0;
        e_in_vld  = '0;
        for (int i = 0; i < NP; i++) begin
            if (m_vld[i]) begin
                e_out_sel[i*SW +: SW]        = SW'(m_sel[i]);
                e_out_vld[i]                 = 1'b1;
                e_in_sel[m_sel[i]*SW +: SW]  = SW'(i);
                e_in_vld[m_sel[i]]           = 1'b1;
            end
        end
        chk("out_sel_vec", 32'(out_sel_vec), 32'(e_out_sel));
        chk("out_vld", 32'(out_vld), 32'(e_out_vld));
        chk("in_sel_vec", 32'(in_sel_vec), 32'(e_in_sel));
        chk("in_vld", 32'(in_vld), 32'(e_in_vld));
        chk("conflict", 32'(conflict), 32'(m_conf));
        chk("multi_hot", 32'(multi_hot), 32'(m_multi));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end

    initial begin
        int cnt_before;
        logic [NP-1:0] rv;
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        alloc_vec   = '0;
        hold_vec    = '0;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // reset state pin
        chk("reset_out_vld", 32'(out_vld), 32'h0);
        chk("reset_cnt", 32'(conflict_cnt), 32'h0);

        // permutation
        alloc_valid = 1'b1;
        for (int i = 0; i < NP; i++) set_row(i, NP'(1 << ((i + 1) % NP)));
        cyc();
        chk("perm_out_sel_lit", 32'(out_sel_vec), 32'({3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}));
        chk("perm_in_sel_lit", 32'(in_sel_vec), 32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5}));
        chk("perm_vld_lit", 32'({in_vld, out_vld}), 32'h0fff);
        chk("perm_conflict_lit", 32'(conflict), 32'h0);

        // contention: inputs 1 and 4 both want output 2
        alloc_vec = '0;
        set_row(1, 6'b000100);
        set_row(4, 6'b000100);
        cnt_before = int'(conflict_cnt);
        cyc();
        chk("cont_out_sel1_lit", 32'(out_sel_vec[1*SW +: SW]), 32'd2);
        chk("cont_out_vld_lit", 32'(out_vld), 32'h02);
        chk("cont_in_sel2_lit", 32'(in_sel_vec[2*SW +: SW]), 32'd1);
        chk("cont_conflict_lit", 32'(conflict), 32'h1);
        chk("cont_cnt_lit", 32'(conflict_cnt), 32'(cnt_before + 1));

        // hold: input 3 owns output 0, input 2 asks for it
        alloc_vec = '0;
        set_row(3, 6'b000001);
        cyc();
        alloc_vec = '0;
        set_row(2, 6'b000001);
        hold_vec  = 6'b001000;
        cyc();
        chk("hold_out_vld_lit", 32'(out_vld), 32'h08);
        chk("hold_in_sel0_lit", 32'(in_sel_vec[0 +: SW]), 32'd3);
        chk("hold_conflict_lit", 32'(conflict), 32'h1);
        hold_vec = '0;
        cyc();
        chk("release_in_sel0_lit", 32'(in_sel_vec[0 +: SW]), 32'd2);
        chk("release_out_vld_lit", 32'(out_vld), 32'h04);

        // multi-hot row
        alloc_vec = '0;
        set_row(0, 6'b010010);
        cyc();
        chk("multi_out_sel0_lit", 32'(out_sel_vec[0 +: SW]), 32'd4);
        chk("multi_flag_lit", 32'(multi_hot), 32'h1);
        alloc_vec = '0;
        cyc();
        chk("multi_pulse_lit", 32'(multi_hot), 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            alloc_valid = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NP; i++) begin
                case ($urandom_range(0, 3))
                    0: rv = '0;
                    1, 2: rv = NP'(1 << $urandom_range(0, NP - 1));
                    default: rv = NP'($urandom);
                endcase
                set_row(i, rv);
            end
            hold_vec = NP'($urandom);
            cyc();
        end

        // reset mid-packet: hold alone must not restore the link
        alloc_valid = 1'b1;
        alloc_vec   = '0;
        hold_vec    = '0;
        set_row(5, 6'b000010);
        cyc();
        hold_vec = 6'b100000;
        alloc_vec = '0;
        cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_out_vld", 32'(out_vld), 32'h0);
        chk("async_rst_in_vld", 32'(in_vld), 32'h0);
        chk("async_rst_cnt", 32'(conflict_cnt), 32'h0);
        hold_vec = 6'b111111;
        alloc_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_hold_lit", 32'(out_vld), 32'h0);
        alloc_valid = 1'b1;
        set_row(0, 6'b001000);
        cyc();
        chk("post_rst_alloc_lit", 32'(in_sel_vec[3*SW +: SW]), 32'd0);
        chk("post_rst_alloc_vld_lit", 32'(out_vld), 32'h01);

        // saturation: 300 contention cycles
        hold_vec  = '0;
        alloc_vec = '0;
        set_row(0, 6'b000001);
        set_row(1, 6'b000001);
        for (int n = 0; n < 300; n++) cyc();
        chk("sat_cnt_lit", 32'(conflict_cnt), 32'd255);
        chk("sat_conflict_lit", 32'(conflict), 32'h1);
        alloc_valid = 1'b0;
        cyc();
        chk("idle_vld_lit", 32'({in_vld, out_vld}), 32'h0);
        chk("idle_pulses_lit", 32'({conflict, multi_hot}), 32'h0);
        chk("idle_cnt_hold_lit", 32'(conflict_cnt), 32'd255);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
